// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the systolic-array processing elements.
// Holds the default format, bias/max-finite helpers and the field/flag structs.
package fp_pkg;

    localparam int EXP_W_DEF = 5;
    localparam int MAN_W_DEF = 10;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive max-finite pattern; callers slice the low 1+exp_w+man_w bits.
    function automatic logic [63:0] max_finite(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd2) << man_w;
        v = v | ((64'd1 << man_w) - 64'd1);
        return v;
    endfunction

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] man;
    } fp_t;

    typedef struct packed {
        logic ovf;
        logic unf;
    } fp_flags_t;

endpackage

// File: rtl/fp_add_norm.sv
// Combinational float adder: align, add/subtract, leading-one normalise,
// then saturate to max-finite or flush to +0 with the matching flag.
module fp_add_norm
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output fp_flags_t    o_flags
);

    localparam logic [63:0] MAX64 = max_finite(EXP_W, MAN_W);
    localparam int EXP_SAT = (1 << EXP_W) - 1;

    logic [W-1:0]       w_x;
    logic [W-1:0]       w_y;
    logic               w_xs;
    logic               w_ys;
    logic [EXP_W-1:0]   w_xe;
    logic [EXP_W-1:0]   w_ye;
    logic [MAN_W+1:0]   w_mx;
    logic [MAN_W+1:0]   w_my;
    logic [MAN_W+1:0]   w_sum;
    logic [MAN_W-1:0]   w_man;
    logic               w_zero;
    int                 w_d;
    int                 w_exp;
    int                 w_lead;

    always_comb begin
        w_x     = i_a;
        w_y     = i_b;
        o_sum   = '0;
        o_flags = '0;
        w_mx    = '0;
        w_my    = '0;
        w_sum   = '0;
        w_man   = '0;
        w_zero  = 1'b0;
        w_d     = 0;
        w_exp   = 0;
        w_lead  = 0;
        // Magnitude order is the unsigned order of exponent:mantissa.
        if (i_b[W-2:0] > i_a[W-2:0]) begin
            w_x = i_b;
            w_y = i_a;
        end
        w_xs = w_x[W-1];
        w_ys = w_y[W-1];
        w_xe = w_x[W-2:MAN_W];
        w_ye = w_y[W-2:MAN_W];

        if (w_xe == '0) begin
            o_sum = '0;
        end else if (w_ye == '0) begin
            o_sum = w_x;
        end else begin
            w_d = int'(w_xe) - int'(w_ye);
            if (w_d > MAN_W + 1) begin
                o_sum = w_x;
            end else begin
                w_mx  = {2'b01, w_x[MAN_W-1:0]};
                w_my  = {2'b01, w_y[MAN_W-1:0]} >> w_d;
                w_exp = int'(w_xe);
                if (w_xs == w_ys) begin
                    w_sum = w_mx + w_my;
                    if (w_sum[MAN_W+1]) begin
                        w_exp = w_exp + 1;
                        w_man = w_sum[MAN_W:1];
                    end else begin
                        w_man = w_sum[MAN_W-1:0];
                    end
                end else begin
                    w_sum = w_mx - w_my;
                    if (w_sum == '0) begin
                        w_zero = 1'b1;
                    end else begin
                        for (int i = 0; i <= MAN_W; i++) begin
                            if (w_sum[i]) w_lead = i;
                        end
                        w_sum = w_sum << (MAN_W - w_lead);
                        w_exp = w_exp - (MAN_W - w_lead);
                        w_man = w_sum[MAN_W-1:0];
                    end
                end

                if (w_zero) begin
                    o_sum = '0;
                end else if (w_exp >= EXP_SAT) begin
                    o_sum       = {w_xs, MAX64[W-2:0]};
                    o_flags.ovf = 1'b1;
                end else if (w_exp <= 0) begin
                    o_sum       = '0;
                    o_flags.unf = 1'b1;
                end else begin
                    o_sum = {w_xs, EXP_W'(w_exp), w_man};
                end
            end
        end
    end

endmodule

// File: rtl/pe_fp_ws.sv
// Weight-stationary float PE: stage 1 multiplies the activation by the held
// weight, stage 2 adds the northern partial sum. en=0 freezes every register.
module pe_fp_ws
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         w_load,
    input  logic [W-1:0] w_in,
    output logic [W-1:0] w_out,
    input  logic [W-1:0] a_in,
    input  logic         a_valid_in,
    output logic [W-1:0] a_out,
    output logic         a_valid_out,
    input  logic [W-1:0] psum_in,
    output logic [W-1:0] psum_out,
    output logic         psum_valid,
    input  logic         clr_flags,
    output logic         ovf_flag,
    output logic         unf_flag
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int BIAS = bias(EXP_W);
    localparam int EXP_SAT = (1 << EXP_W) - 1;
    localparam logic [63:0] MAX64 = max_finite(EXP_W, MAN_W);

    logic [W-1:0]     r_weight;
    logic [W-1:0]     r_a_out;
    logic             r_a_valid;
    logic [W-1:0]     r_prod;
    fp_flags_t        r_prod_flags;
    logic             r_v1;
    logic [W-1:0]     r_psum;
    logic             r_psum_valid;
    logic             r_ovf;
    logic             r_unf;

    logic [W-1:0]     w_prod;
    fp_flags_t        w_mul_flags;
    logic [PW-1:0]    w_pm;
    logic [MAN_W-1:0] w_pman;
    int               w_pexp;
    logic [EXP_W-1:0] w_ae;
    logic [EXP_W-1:0] w_we;
    logic             w_ps;
    logic [W-1:0]     w_add_sum;
    fp_flags_t        w_add_flags;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    assign w_ae = a_in[W-2:MAN_W];
    assign w_we = r_weight[W-2:MAN_W];
    assign w_ps = a_in[W-1] ^ r_weight[W-1];

    always_comb begin
        w_prod      = '0;
        w_mul_flags = '0;
        w_pm        = '0;
        w_pman      = '0;
        w_pexp      = 0;
        // Either operand with a zero exponent field counts as +0.
        if (w_ae != '0 && w_we != '0) begin
            w_pm   = PW'({1'b1, a_in[MAN_W-1:0]}) * PW'({1'b1, r_weight[MAN_W-1:0]});
            w_pexp = int'(w_ae) + int'(w_we) - BIAS;
            if (w_pm[PW-1]) begin
                w_pexp = w_pexp + 1;
                w_pman = w_pm[PW-2:MAN_W+1];
            end else begin
                w_pman = w_pm[PW-3:MAN_W];
            end
            if (w_pexp >= EXP_SAT) begin
                w_prod          = {w_ps, MAX64[W-2:0]};
                w_mul_flags.ovf = 1'b1;
            end else if (w_pexp <= 0) begin
                w_prod          = '0;
                w_mul_flags.unf = 1'b1;
            end else begin
                w_prod = {w_ps, EXP_W'(w_pexp), w_pman};
            end
        end
    end

    fp_add_norm #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_add (
        .i_a     (r_prod),
        .i_b     (psum_in),
        .o_sum   (w_add_sum),
        .o_flags (w_add_flags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_weight     <= '0;
            r_a_out      <= '0;
            r_a_valid    <= 1'b0;
            r_prod       <= '0;
            r_prod_flags <= '0;
            r_v1         <= 1'b0;
            r_psum       <= '0;
            r_psum_valid <= 1'b0;
        end else if (en) begin
            if (w_load) r_weight <= w_in;
            r_a_out      <= a_in;
            r_a_valid    <= a_valid_in;
            r_prod       <= w_prod;
            r_prod_flags <= w_mul_flags;
            r_v1         <= a_valid_in;
            r_psum_valid <= r_v1;
            if (r_v1) r_psum <= w_add_sum;
        end
    end

    // Product flags ride with the product and only count once v1 confirms it.
    assign w_ovf_evt = en & r_v1 & (r_prod_flags.ovf | w_add_flags.ovf);
    assign w_unf_evt = en & r_v1 & (r_prod_flags.unf | w_add_flags.unf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~clr_flags) | w_ovf_evt;
            r_unf <= (r_unf & ~clr_flags) | w_unf_evt;
        end
    end

    assign w_out       = r_weight;
    assign a_out       = r_a_out;
    assign a_valid_out = r_a_valid;
    assign psum_out    = r_psum;
    assign psum_valid  = r_psum_valid;
    assign ovf_flag    = r_ovf;
    assign unf_flag    = r_unf;

endmodule

// File: tb/tb_pe_fp_ws.sv
// Self-checking bench for pe_fp_ws (fp16 defaults): directed MAC cases with an
// expected-result queue popped whenever an enabled edge produces psum_valid.
module tb_pe_fp_ws;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         w_load = 1'b0;
    logic [W-1:0] w_in = '0;
    logic [W-1:0] w_out;
    logic [W-1:0] a_in = '0;
    logic         a_valid_in = 1'b0;
    logic [W-1:0] a_out;
    logic         a_valid_out;
    logic [W-1:0] psum_in = '0;
    logic [W-1:0] psum_out;
    logic         psum_valid;
    logic         clr_flags = 1'b0;
    logic         ovf_flag;
    logic         unf_flag;

    int           n_checks = 0;
    int           n_errors = 0;
    logic         last_en = 1'b0;
    logic [W-1:0] exp_q[$];

    pe_fp_ws dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .w_load      (w_load),
        .w_in        (w_in),
        .w_out       (w_out),
        .a_in        (a_in),
        .a_valid_in  (a_valid_in),
        .a_out       (a_out),
        .a_valid_out (a_valid_out),
        .psum_in     (psum_in),
        .psum_out    (psum_out),
        .psum_valid  (psum_valid),
        .clr_flags   (clr_flags),
        .ovf_flag    (ovf_flag),
        .unf_flag    (unf_flag)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [W-1:0] w);
        w_load = 1'b1;
        w_in   = w;
        tick();
        w_load = 1'b0;
    endtask

    // One isolated MAC: activation at edge t, psum_in for edge t+1.
    task automatic mac(input logic [W-1:0] a, input logic [W-1:0] ps, input logic [W-1:0] exp);
        a_in       = a;
        a_valid_in = 1'b1;
        exp_q.push_back(exp);
        tick();
        a_valid_in = 1'b0;
        psum_in    = ps;
        tick();
    endtask

    // scoreboard monitor: one result per enabled edge with psum_valid
    always @(posedge clk) last_en = en & ~reset;

    always @(negedge clk) begin
        if (!reset && last_en && psum_valid) begin
            if (exp_q.size() == 0) chk("extra_result", 1, 0);
            else chk("psum_out", {16'h0, psum_out}, {16'h0, exp_q.pop_front()});
        end
    end

    logic [W-1:0] s_a[4];
    logic [W-1:0] s_exp[4];

    initial begin
        s_a   = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        s_exp = '{16'h4000, 16'h4200, 16'h4400, 16'h4500};

        // reset state
        #3;
        chk("rst_w_out", w_out, 0);
        chk("rst_a_valid", a_valid_out, 0);
        chk("rst_psum", {psum_valid, psum_out}, 0);
        chk("rst_flags", {ovf_flag, unf_flag}, 0);
        tick();
        tick();
        reset = 1'b0;
        en    = 1'b1;

        // weight chain
        load_w(16'h4000);
        chk("w_chain0", w_out, 16'h4000);
        load_w(16'h3C00);
        chk("w_chain1", w_out, 16'h3C00);

        // basic MAC: 1.5 * 2.0 + 1.0 = 4.0
        load_w(16'h3E00);
        a_in       = 16'h4000;
        a_valid_in = 1'b1;
        exp_q.push_back(16'h4400);
        tick();
        chk("a_out", a_out, 16'h4000);
        chk("a_valid_out", a_valid_out, 1);
        chk("psum_valid_early", psum_valid, 0);
        a_valid_in = 1'b0;
        psum_in    = 16'h3C00;
        tick();
        chk("psum_valid", psum_valid, 1);
        tick();
        chk("psum_valid_drop", psum_valid, 0);
        chk("psum_hold", psum_out, 16'h4400);

        // overflow: saturates and sticks until cleared
        load_w(16'h4000);
        mac(16'h7800, 16'h0000, 16'h7BFF);
        chk("ovf_set", ovf_flag, 1);
        chk("unf_quiet", unf_flag, 0);
        tick();
        tick();
        chk("ovf_sticky", ovf_flag, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovf_clr", ovf_flag, 0);

        // underflow: 0.5 * 2^-14 flushes to +0
        load_w(16'h3800);
        mac(16'h0400, 16'h0000, 16'h0000);
        chk("unf_set", unf_flag, 1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("unf_clr", unf_flag, 0);

        // exact cancellation: 3.0 + -3.0
        load_w(16'h3C00);
        mac(16'h4200, 16'hC200, 16'h0000);
        chk("cancel_flags", {ovf_flag, unf_flag}, 0);

        // back-to-back stream with a 3-cycle stall before the third edge
        for (int i = 0; i <= 4; i++) begin
            a_in       = (i < 4) ? s_a[i] : 16'h0;
            a_valid_in = (i < 4);
            psum_in    = (i > 0) ? 16'h3C00 : 16'h0;
            if (i < 4) exp_q.push_back(s_exp[i]);
            if (i == 2) begin
                en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("stall_a_out", {a_valid_out, a_out}, {1'b1, 16'h4000});
                    chk("stall_psum", {psum_valid, psum_out}, {1'b1, 16'h4000});
                end
                en = 1'b1;
            end
            tick();
        end
        a_valid_in = 1'b0;
        psum_in    = 16'h0;
        tick();
        chk("stream_drain", exp_q.size(), 0);

        // reset with a stage-2 valid pending
        load_w(16'h4000);
        mac(16'h7800, 16'h0000, 16'h7BFF);
        a_in       = 16'h7800;
        a_valid_in = 1'b1;
        tick();
        a_valid_in = 1'b0;
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_a", {a_valid_out, a_out}, 0);
        chk("mid_rst_psum", {psum_valid, psum_out}, 0);
        chk("mid_rst_flags", {ovf_flag, unf_flag}, 0);
        chk("mid_rst_w", w_out, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_valid", psum_valid, 0);

        // weight load colliding with an activation uses the old weight
        load_w(16'h4000);
        w_load     = 1'b1;
        w_in       = 16'h4200;
        a_in       = 16'h3C00;
        a_valid_in = 1'b1;
        psum_in    = 16'h0;
        exp_q.push_back(16'h4000);
        tick();
        w_load = 1'b0;
        exp_q.push_back(16'h4200);
        tick();
        a_valid_in = 1'b0;
        tick();
        chk("collide_w_out", w_out, 16'h4200);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
